// File: rtl/qoa_pkg.sv
// qoa_pkg: shared states, error codes and QOA framing constants; QOA_FILE_HEADER_EN adds the file-header state
package qoa_pkg;
  typedef enum logic [2:0] {
`ifdef QOA_FILE_HEADER_EN
    S_FILE_HDR,
`endif
    S_HDR,
    S_LMS,
    S_SLICES,
    S_ERROR
  } qoa_state_e;
`ifdef QOA_FILE_HEADER_EN
  localparam qoa_state_e S_INIT = S_FILE_HDR;
`else
  localparam qoa_state_e S_INIT = S_HDR;
`endif
  localparam logic [1:0] ERR_NONE = 2'd0, ERR_BAD_HDR = 2'd1, ERR_OVERRUN = 2'd2, ERR_SIZE = 2'd3;
  localparam int QOA_HDR_BYTES = 8, QOA_LMS_BYTES = 16, QOA_SLICE_BYTES = 8, QOA_SLICE_LEN = 20;
  localparam logic [31:0] QOA_MAGIC = 32'h716f6166;
endpackage

// File: rtl/qoa_frame_sequencer_if.sv
// qoa_frame_sequencer_if: rx byte stream in, channel-tagged slice stream out
interface qoa_frame_sequencer_if #(parameter int CH_W = 1);
  logic rx_valid;
  logic [7:0] rx_data;
  logic slice_valid, slice_ready, slice_last;
  logic [63:0] slice_data;
  logic [CH_W-1:0] slice_ch;
  modport master(input rx_valid, rx_data, slice_ready, output slice_valid, slice_data, slice_ch, slice_last);
  modport slave(output rx_valid, rx_data, slice_ready, input slice_valid, slice_data, slice_ch, slice_last);
endinterface

// File: rtl/qoa_slice_assembler.sv
// qoa_slice_assembler: 8-byte assembly into a one-entry holding register with valid/ready and overrun detect
module qoa_slice_assembler
  import qoa_pkg::*;
#(
  parameter int CH_W = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            freeze,
  input  logic [7:0]      byte_in,
  input  logic [CH_W-1:0] tag_ch,
  input  logic            tag_last,
  input  logic            slice_ready,
  output logic            complete,
  output logic            overrun,
  output logic            slice_valid,
  output logic [63:0]     slice_data,
  output logic [CH_W-1:0] slice_ch,
  output logic            slice_last
);
  logic [2:0] cnt;
  logic [55:0] asm_q;
  logic go, take, load;
  assign go = push && !freeze;
  assign complete = go && cnt == 3'(QOA_SLICE_BYTES - 1);
  assign take = slice_valid && slice_ready && !freeze;
  assign load = complete && (!slice_valid || slice_ready);
  assign overrun = complete && !load;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= 3'd0;
      asm_q <= 56'd0;
      slice_valid <= 1'b0;
      slice_data <= 64'd0;
      slice_ch <= '0;
      slice_last <= 1'b0;
    end else begin
      if (go) begin
        cnt <= cnt + 3'd1;
        asm_q <= {asm_q[47:0], byte_in};
      end
      if (load) begin
        slice_data <= {asm_q, byte_in};
        slice_ch <= tag_ch;
        slice_last <= tag_last;
      end
      if (load || take) slice_valid <= load;
    end
endmodule

// File: rtl/qoa_frame_sequencer.sv
// qoa_frame_sequencer: parses QOA frame headers, loads LMS state, hands out tagged slices.
// QOA_FILE_HEADER_EN: consume an 8-byte "qoaf" file header before the first frame.
module qoa_frame_sequencer
  import qoa_pkg::*;
#(
  parameter int MAX_CH = 2,
  localparam int CH_W = MAX_CH > 1 ? $clog2(MAX_CH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  qoa_frame_sequencer_if.master bus,
  output logic                 lms_we,
  output logic [CH_W-1:0]      lms_ch,
  output logic [2:0]           lms_idx,
  output logic [15:0]          lms_wdata,
  output logic                 frame_start,
  output logic [7:0]           num_ch,
  output logic [23:0]          samplerate,
  output logic [15:0]          fsamples,
  output logic                 busy,
  output logic                 err,
  output logic [1:0]           err_code
);
  qoa_state_e state_q, state_n;
  logic [3:0] cnt_q, cnt_n;
  logic [55:0] sr_q;
  logic [63:0] hdr;
  logic [7:0] ch_q;
  logic [15:0] samples_left, fsize_q, frame_bytes, fb_n;
  logic [1:0] code_n;
  logic rx, hdr_done, hdr_bad, ch_last, lms_step, lms_done, tag_last, push, complete, overrun, load;
  assign rx = bus.rx_valid && state_q != S_ERROR;
  assign hdr = {sr_q, bus.rx_data};
  assign hdr_done = rx && state_q == S_HDR && cnt_q == 4'(QOA_HDR_BYTES - 1);
  assign hdr_bad = hdr[63:56] == 8'd0 || hdr[63:56] > 8'(MAX_CH) || hdr[31:16] == 16'd0;
  assign ch_last = ch_q + 8'd1 == num_ch;
  assign lms_step = rx && state_q == S_LMS;
  assign lms_done = lms_step && cnt_q == 4'(QOA_LMS_BYTES - 1) && ch_last;
  assign tag_last = samples_left <= 16'(QOA_SLICE_LEN) && ch_last;
  assign push = rx && state_q == S_SLICES;
  assign load = complete && !overrun;
  assign fb_n = state_q == S_HDR && cnt_q == 4'd0 ? 16'd1 : frame_bytes + 16'd1;
  always_comb begin
    state_n = state_q;
    code_n = ERR_NONE;
    cnt_n = cnt_q;
    if (rx && state_q != S_SLICES)
      cnt_n = state_q != S_LMS && cnt_q == 4'(QOA_HDR_BYTES - 1) ? 4'd0 : cnt_q + 4'd1;
`ifdef QOA_FILE_HEADER_EN
    if (rx && state_q == S_FILE_HDR && cnt_q == 4'(QOA_HDR_BYTES - 1)) begin
      state_n = hdr[63:32] == QOA_MAGIC ? S_HDR : S_ERROR;
      code_n = hdr[63:32] == QOA_MAGIC ? ERR_NONE : ERR_BAD_HDR;
    end
`endif
    if (hdr_done) begin
      state_n = hdr_bad ? S_ERROR : S_LMS;
      code_n = hdr_bad ? ERR_BAD_HDR : ERR_NONE;
    end else if (lms_done) begin
      state_n = S_SLICES;
    end else if (overrun) begin
      state_n = S_ERROR;
      code_n = ERR_OVERRUN;
    end else if (load && tag_last) begin
      state_n = fb_n == fsize_q ? S_HDR : S_ERROR;
      code_n = fb_n == fsize_q ? ERR_NONE : ERR_SIZE;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_INIT;
      cnt_q <= 4'd0;
      busy <= 1'b0;
      err <= 1'b0;
      err_code <= ERR_NONE;
    end else begin
      state_q <= state_n;
      cnt_q <= cnt_n;
      busy <= !(state_n == S_HDR && cnt_n == 4'd0);
      if (state_q != S_ERROR && state_n == S_ERROR) begin
        err <= 1'b1;
        err_code <= code_n;
      end
    end
  // hdr doubles as the byte-pair window: hdr[15:0] is the big-endian LMS word
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sr_q <= 56'd0;
      ch_q <= 8'd0;
      samples_left <= 16'd0;
      fsize_q <= 16'd0;
      frame_bytes <= 16'd0;
      lms_we <= 1'b0;
      lms_ch <= '0;
      lms_idx <= 3'd0;
      lms_wdata <= 16'd0;
      frame_start <= 1'b0;
      num_ch <= 8'd0;
      samplerate <= 24'd0;
      fsamples <= 16'd0;
    end else begin
      lms_we <= lms_step && cnt_q[0];
      frame_start <= hdr_done && !hdr_bad;
      if (rx) begin
        sr_q <= hdr[55:0];
        frame_bytes <= fb_n;
      end
      if (hdr_done) begin
        num_ch <= hdr[63:56];
        samplerate <= hdr[55:32];
        fsamples <= hdr[31:16];
        fsize_q <= hdr[15:0];
        samples_left <= hdr[31:16];
        ch_q <= 8'd0;
      end
      if (lms_step && cnt_q[0]) begin
        lms_ch <= ch_q[CH_W-1:0];
        lms_idx <= cnt_q[3:1];
        lms_wdata <= hdr[15:0];
      end
      if ((lms_step && cnt_q == 4'(QOA_LMS_BYTES - 1)) || load) ch_q <= ch_last ? 8'd0 : ch_q + 8'd1;
      if (load && ch_last) samples_left <= samples_left - 16'(QOA_SLICE_LEN);
    end
  qoa_slice_assembler #(.CH_W(CH_W)) u_asm (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .freeze(state_q == S_ERROR),
    .byte_in(bus.rx_data),
    .tag_ch(ch_q[CH_W-1:0]),
    .tag_last(tag_last),
    .slice_ready(bus.slice_ready),
    .complete(complete),
    .overrun(overrun),
    .slice_valid(bus.slice_valid),
    .slice_data(bus.slice_data),
    .slice_ch(bus.slice_ch),
    .slice_last(bus.slice_last)
  );
endmodule

// File: tb/tb_qoa_frame_sequencer.sv
// tb_qoa_frame_sequencer: directed scenarios with random payloads against a frame-level reference model
module tb_qoa_frame_sequencer;
  import qoa_pkg::*;
  localparam int MAX_CH = 2;
  localparam int CH_W = 1;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  qoa_frame_sequencer_if #(.CH_W(CH_W)) bus ();
  logic lms_we, frame_start, busy, err;
  logic [CH_W-1:0] lms_ch;
  logic [2:0] lms_idx;
  logic [15:0] lms_wdata, fsamples;
  logic [7:0] num_ch;
  logic [23:0] samplerate;
  logic [1:0] err_code;
  qoa_frame_sequencer #(.MAX_CH(MAX_CH)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .lms_we(lms_we), .lms_ch(lms_ch), .lms_idx(lms_idx), .lms_wdata(lms_wdata),
    .frame_start(frame_start), .num_ch(num_ch), .samplerate(samplerate), .fsamples(fsamples),
    .busy(busy), .err(err), .err_code(err_code)
  );
  int tests = 0, fails = 0, starts = 0, rdy_mode = 2;
  logic [31:0] got_lms[$], exp_lms[$];
  logic [71:0] got_sl[$], exp_sl[$];
  logic [7:0] stream[$];
  logic [7:0] e_nch;
  logic [23:0] e_sr;
  logic [15:0] e_fs;
  always @(negedge clk)
    if (rst_n) begin
      if (lms_we) got_lms.push_back({8'(lms_ch), 5'd0, lms_idx, lms_wdata});
      if (bus.slice_valid && bus.slice_ready)
        got_sl.push_back({4'(bus.slice_ch), 3'd0, bus.slice_last, bus.slice_data});
      if (frame_start) starts++;
    end
  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    bus.slice_ready = rdy_mode == 1 || (rdy_mode == 2 && (!bus.slice_ready || $urandom_range(0, 1) == 1));
  endtask
  function automatic int fsize_of(input int nch, input int fs);
    return 8 + 16 * nch + 8 * nch * ((fs + 19) / 20);
  endfunction
  task automatic make_frame(input logic [7:0] nch, input logic [23:0] sr, input logic [15:0] fs, input logic [15:0] fsz);
    int ng;
    logic [15:0] v;
    logic [63:0] d;
    ng = (int'(fs) + 19) / 20;
    e_nch = nch; e_sr = sr; e_fs = fs;
    stream = {nch, sr[23:16], sr[15:8], sr[7:0], fs[15:8], fs[7:0], fsz[15:8], fsz[7:0]};
    for (int c = 0; c < int'(nch); c++)
      for (int i = 0; i < 8; i++) begin
        v = 16'($urandom);
        stream.push_back(v[15:8]);
        stream.push_back(v[7:0]);
        exp_lms.push_back({8'(c), 5'd0, 3'(i), v});
      end
    for (int g = 0; g < ng; g++)
      for (int c = 0; c < int'(nch); c++) begin
        d = {$urandom, $urandom};
        for (int k = 7; k >= 0; k--) stream.push_back(d[k*8 +: 8]);
        exp_sl.push_back({4'(c), 3'd0, 1'(g == ng - 1 && c == int'(nch) - 1), d});
      end
  endtask
  task automatic send_bytes(input int n);
    for (int i = 0; i < n && stream.size() > 0; i++) begin
      bus.rx_valid = 1'b1;
      bus.rx_data = stream.pop_front();
      tick();
      bus.rx_valid = 1'b0;
      if ($urandom_range(0, 2) == 0) tick();
    end
  endtask
  task automatic clear_q();
    got_lms = {}; exp_lms = {}; got_sl = {}; exp_sl = {}; starts = 0;
  endtask
  task automatic reset_dut();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    clear_q();
  endtask
  task automatic check_frame(input string tag);
    int n;
    repeat (4) tick();
    chk({tag, " lms count"}, 72'(got_lms.size()), 72'(exp_lms.size()));
    n = got_lms.size() < exp_lms.size() ? got_lms.size() : exp_lms.size();
    for (int i = 0; i < n; i++) chk({tag, " lms"}, 72'(got_lms[i]), 72'(exp_lms[i]));
    chk({tag, " slice count"}, 72'(got_sl.size()), 72'(exp_sl.size()));
    n = got_sl.size() < exp_sl.size() ? got_sl.size() : exp_sl.size();
    for (int i = 0; i < n; i++) chk({tag, " slice"}, got_sl[i], exp_sl[i]);
    chk({tag, " frame_start"}, 72'(starts), 72'(1));
    chk({tag, " num_ch"}, 72'(num_ch), 72'(e_nch));
    chk({tag, " samplerate"}, 72'(samplerate), 72'(e_sr));
    chk({tag, " fsamples"}, 72'(fsamples), 72'(e_fs));
    chk({tag, " err"}, 72'(err), 72'(0));
    chk({tag, " busy"}, 72'(busy), 72'(0));
    clear_q();
  endtask
  initial begin
    logic [63:0] first;
    logic [7:0] nch;
    logic [15:0] fs;
    bus.rx_valid = 1'b0;
    bus.rx_data = 8'd0;
    bus.slice_ready = 1'b0;
    #2 rst_n = 1'b0;
    #10;
    chk("rst err", 72'(err), 72'(0));
    chk("rst err_code", 72'(err_code), 72'(ERR_NONE));
    chk("rst slice_valid", 72'(bus.slice_valid), 72'(0));
    chk("rst lms_we", 72'(lms_we), 72'(0));
    chk("rst frame_start", 72'(frame_start), 72'(0));
    chk("rst busy", 72'(busy), 72'(0));
    chk("rst cfg", 72'({num_ch, samplerate, fsamples}), 72'(0));
    tick();
    rst_n = 1'b1;
    tick();
    clear_q();
    make_frame(8'd1, 24'h00AC44, 16'd40, 16'h0028);
    send_bytes(1000);
    check_frame("one_ch");
    make_frame(8'd2, 24'd44100, 16'd21, 16'h0048);
    send_bytes(1000);
    check_frame("two_ch");
    for (int i = 0; i < 6; i++) begin
      nch = 8'($urandom_range(1, 2));
      fs = i == 0 ? 16'd20 : i == 1 ? 16'd1 : 16'($urandom_range(2, 100));
      make_frame(nch, 24'($urandom), fs, 16'(fsize_of(int'(nch), int'(fs))));
      send_bytes(1000);
      check_frame("rand");
    end
    make_frame(8'd3, 24'd48000, 16'd20, 16'(fsize_of(3, 20)));
    send_bytes(8);
    chk("bad_nch err", 72'(err), 72'(1));
    chk("bad_nch code", 72'(err_code), 72'(ERR_BAD_HDR));
    send_bytes(1000);
    repeat (3) tick();
    chk("bad_nch no lms", 72'(got_lms.size()), 72'(0));
    chk("bad_nch no slice", 72'(got_sl.size()), 72'(0));
    chk("bad_nch slice_valid", 72'(bus.slice_valid), 72'(0));
    chk("bad_nch no start", 72'(starts), 72'(0));
    reset_dut();
    make_frame(8'd1, 24'd8000, 16'd0, 16'd24);
    send_bytes(8);
    chk("bad_fs code", 72'({err, err_code}), 72'({1'b1, ERR_BAD_HDR}));
    reset_dut();
    rdy_mode = 0;
    tick();
    make_frame(8'd1, 24'h00AC44, 16'd40, 16'h0028);
    first = exp_sl[0][63:0];
    send_bytes(32);
    chk("ovr pre err", 72'(err), 72'(0));
    chk("ovr pre valid", 72'(bus.slice_valid), 72'(1));
    send_bytes(8);
    chk("ovr err", 72'(err), 72'(1));
    chk("ovr code", 72'(err_code), 72'(ERR_OVERRUN));
    chk("ovr valid", 72'(bus.slice_valid), 72'(1));
    chk("ovr kept data", 72'(bus.slice_data), 72'(first));
    chk("ovr kept last", 72'(bus.slice_last), 72'(0));
    rdy_mode = 2;
    reset_dut();
    make_frame(8'd1, 24'h00AC44, 16'd40, 16'h0029);
    send_bytes(1000);
    chk("size err", 72'(err), 72'(1));
    chk("size code", 72'(err_code), 72'(ERR_SIZE));
    reset_dut();
    make_frame(8'd1, 24'h00AC44, 16'd40, 16'h0028);
    send_bytes(28);
    rst_n = 1'b0;
    #1;
    chk("midrst slice_valid", 72'(bus.slice_valid), 72'(0));
    chk("midrst busy", 72'(busy), 72'(0));
    chk("midrst err", 72'(err), 72'(0));
    tick();
    rst_n = 1'b1;
    tick();
    clear_q();
    make_frame(8'd1, 24'h00AC44, 16'd40, 16'h0028);
    send_bytes(1000);
    check_frame("after_rst");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
